// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32IM 5-stage pipeline hazard controller
//
// Resolves data and control hazards for the 5-stage core:
//   - execute-stage operand forwarding selects (M has priority over W)
//   - load-use stall (hold F/D, bubble into E)
//   - taken branch/jump flush (bubble into D and E)
//   - multi-cycle divide/remainder sequencing (IDLE/BUSY FSM + down counter)
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters; otherwise stallCount/flushCount are tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   regAddr1D/2D             rs1/rs2 of instruction in D
//   regAddr1E/2E/3E          rs1/rs2/rd of instruction in E
//   resultSelE               result select in E (2'b01 = load)
//   regWriteM/regAddr3M      M-stage write enable / rd
//   regWriteW/regAddr3W      W-stage write enable / rd
//   pcSrcE                   taken branch/jump resolved in E
//   divStartE                div/divu/rem/remu in E
//   stallF/stallD/stallE     hold pipeline registers
//   flushD/flushE/flushM     bubble into D/E/M
//   forwardAE/forwardBE      00 regfile, 01 from W, 10 from M
//   divBusy/divDone          divide sequencer occupied / result valid pulse
//   stallCount/flushCount    32-bit perf counters

module hazard_unit #(
  parameter int RF_WIDTH   = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RF_WIDTH-1:0] regAddr1D,
  input  logic [RF_WIDTH-1:0] regAddr2D,
  input  logic [RF_WIDTH-1:0] regAddr1E,
  input  logic [RF_WIDTH-1:0] regAddr2E,
  input  logic [RF_WIDTH-1:0] regAddr3E,
  input  logic [1:0]          resultSelE,
  input  logic                regWriteM,
  input  logic [RF_WIDTH-1:0] regAddr3M,
  input  logic                regWriteW,
  input  logic [RF_WIDTH-1:0] regAddr3W,
  input  logic                pcSrcE,
  input  logic                divStartE,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                flushD,
  output logic                flushE,
  output logic                flushM,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                divBusy,
  output logic                divDone,
  output logic [31:0]         stallCount,
  output logic [31:0]         flushCount
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_stall;
  logic                 lw_stall;
  logic [1:0]           fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [RF_WIDTH-1:0] src);
    if (regWriteM && (regAddr3M != '0) && (regAddr3M == src))
      return 2'b10;
    else if (regWriteW && (regAddr3W != '0) && (regAddr3W == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(regAddr1E);
  assign fwd_b = fwd_sel(regAddr2E);

  assign lw_stall = (resultSelE == 2'b01) && (regAddr3E != '0) &&
                    ((regAddr3E == regAddr1D) || (regAddr3E == regAddr2D));

  // The start cycle stalls too, so the counter is loaded with DIV_CYCLES-1
  // to make the total exactly DIV_CYCLES. The cnt==0 cycle releases the
  // stall and ignores divStartE so the op leaving E cannot restart itself.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (divStartE) begin
          div_stall = 1'b1;
          state_d   = S_BUSY;
          cnt_d     = CNT_INIT;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          div_stall = 1'b1;
          cnt_d     = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst so a combinational divStartE/pcSrcE cannot
  // leak through while reset is held. The divide stall masks both flushes
  // in D/E; a branch flush overrides the load-use hold.
  assign stallE    = ~rst & div_stall;
  assign stallF    = ~rst & (div_stall | (lw_stall & ~pcSrcE));
  assign stallD    = stallF;
  assign flushD    = ~rst & ~div_stall & pcSrcE;
  assign flushE    = ~rst & ~div_stall & (lw_stall | pcSrcE);
  assign flushM    = ~rst & div_stall;
  assign divBusy   = ~rst & (state_q == S_BUSY);
  assign divDone   = divBusy & (cnt_q == '0);
  assign forwardAE = rst ? 2'b00 : fwd_a;
  assign forwardBE = rst ? 2'b00 : fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flushD | flushE | flushM)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = 32'd0;
  assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scoreboard bench for hazard_unit

module tb_hazard_unit;

  localparam int RF_WIDTH   = 5;
  localparam int DIV_CYCLES = 4;
  localparam int CNT_WIDTH  = 8;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL_CNT = 32'd5;
  localparam logic [31:0] EXP_FLUSH_CNT = 32'd6;
`else
  localparam logic [31:0] EXP_STALL_CNT = 32'd0;
  localparam logic [31:0] EXP_FLUSH_CNT = 32'd0;
`endif

  logic                clk;
  logic                rst;
  logic [RF_WIDTH-1:0] regAddr1D, regAddr2D, regAddr1E, regAddr2E, regAddr3E;
  logic [1:0]          resultSelE;
  logic                regWriteM, regWriteW;
  logic [RF_WIDTH-1:0] regAddr3M, regAddr3W;
  logic                pcSrcE, divStartE;
  logic                stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0]          forwardAE, forwardBE;
  logic                divBusy, divDone;
  logic [31:0]         stallCount, flushCount;

  hazard_unit #(
    .RF_WIDTH  (RF_WIDTH),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .regAddr1D (regAddr1D),
    .regAddr2D (regAddr2D),
    .regAddr1E (regAddr1E),
    .regAddr2E (regAddr2E),
    .regAddr3E (regAddr3E),
    .resultSelE(resultSelE),
    .regWriteM (regWriteM),
    .regAddr3M (regAddr3M),
    .regWriteW (regWriteW),
    .regAddr3W (regAddr3W),
    .pcSrcE    (pcSrcE),
    .divStartE (divStartE),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .flushD    (flushD),
    .flushE    (flushE),
    .flushM    (flushM),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
    .divBusy   (divBusy),
    .divDone   (divDone),
    .stallCount(stallCount),
    .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;

  item_t sb_q[$];
  int    n_compared = 0;
  int    n_mismatched = 0;

  // {stallF,stallD,stallE,flushD,flushE,flushM,forwardAE,forwardBE,divBusy,divDone}
  function automatic logic [11:0] v(input logic sf, input logic sd, input logic se,
                                    input logic fd, input logic fe, input logic fm,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input logic busy, input logic done);
    return {sf, sd, se, fd, fe, fm, fa, fb, busy, done};
  endfunction

  localparam logic [11:0] IDLE_V = 12'h000;

  function automatic logic [11:0] ctl();
    return {stallF, stallD, stallE, flushD, flushE, flushM,
            forwardAE, forwardBE, divBusy, divDone};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    item_t it;
    if (sb_q.size() == 0) begin
      n_mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      it = sb_q.pop_front();
      n_compared++;
      assert (obs === it.exp) else begin
        n_mismatched++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Inputs are driven #1 after a rising edge; outputs are sampled 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input string tag, input logic [11:0] e);
    push(tag, {20'd0, e});
    #3;
    pop_cmp({20'd0, ctl()});
  endtask

  task automatic clear_inputs();
    regAddr1D = '0; regAddr2D = '0; regAddr1E = '0; regAddr2E = '0; regAddr3E = '0;
    resultSelE = 2'b00; regWriteM = 1'b0; regAddr3M = '0; regWriteW = 1'b0;
    regAddr3W = '0; pcSrcE = 1'b0; divStartE = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    pcSrcE = 1'b1;
    divStartE = 1'b1;
    #2;
    expect_ctl("reset_outputs_gated", IDLE_V);
    push("reset_stall_cnt", 32'd0); pop_cmp(stallCount);
    push("reset_flush_cnt", 32'd0); pop_cmp(flushCount);

    next_cycle();
    rst = 1'b0;
    clear_inputs();
    expect_ctl("idle_after_reset", IDLE_V);

    // Forwarding
    next_cycle();
    regWriteM = 1'b1; regAddr3M = 5'd5; regWriteW = 1'b1; regAddr3W = 5'd5; regAddr1E = 5'd5;
    expect_ctl("fwdA_from_M_priority", v(0,0,0,0,0,0,2'b10,2'b00,0,0));
    next_cycle();
    regWriteM = 1'b0;
    expect_ctl("fwdA_from_W", v(0,0,0,0,0,0,2'b01,2'b00,0,0));
    next_cycle();
    regWriteM = 1'b1; regAddr3M = 5'd0; regAddr3W = 5'd0; regAddr1E = 5'd0;
    expect_ctl("fwdA_x0_never", IDLE_V);
    next_cycle();
    regAddr3M = 5'd9; regAddr2E = 5'd9; regAddr3W = 5'd9; regAddr1E = 5'd3;
    expect_ctl("fwdB_from_M", v(0,0,0,0,0,0,2'b00,2'b10,0,0));
    next_cycle();
    regWriteM = 1'b0;
    expect_ctl("fwdB_from_W", v(0,0,0,0,0,0,2'b00,2'b01,0,0));

    // Load-use
    next_cycle();
    clear_inputs();
    resultSelE = 2'b01; regAddr3E = 5'd7; regAddr2D = 5'd7;
    expect_ctl("load_use_stall", v(1,1,0,0,1,0,2'b00,2'b00,0,0));
    next_cycle();
    resultSelE = 2'b00;
    expect_ctl("load_use_released", IDLE_V);
    next_cycle();
    resultSelE = 2'b01; regAddr3E = 5'd0; regAddr2D = 5'd0;
    expect_ctl("load_use_x0_none", IDLE_V);

    // Branch
    next_cycle();
    clear_inputs();
    pcSrcE = 1'b1;
    expect_ctl("branch_flush", v(0,0,0,1,1,0,2'b00,2'b00,0,0));
    next_cycle();
    pcSrcE = 1'b0;
    expect_ctl("branch_one_cycle", IDLE_V);
    next_cycle();
    pcSrcE = 1'b1; resultSelE = 2'b01; regAddr3E = 5'd4; regAddr1D = 5'd4;
    expect_ctl("branch_beats_load_use", v(0,0,0,1,1,0,2'b00,2'b00,0,0));

    // Divide with DIV_CYCLES=4, divStartE held through the done cycle
    next_cycle();
    clear_inputs();
    divStartE = 1'b1;
    expect_ctl("div_start", v(1,1,1,0,0,1,2'b00,2'b00,0,0));
    next_cycle();
    pcSrcE = 1'b1; resultSelE = 2'b01; regAddr3E = 5'd4; regAddr1D = 5'd4;
    expect_ctl("div_masks_branch_lw", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    next_cycle();
    pcSrcE = 1'b0; resultSelE = 2'b00;
    expect_ctl("div_stall_3", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    next_cycle();
    expect_ctl("div_stall_4", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    next_cycle();
    expect_ctl("div_done", v(0,0,0,0,0,0,2'b00,2'b00,1,1));
    next_cycle();
    divStartE = 1'b0;
    expect_ctl("div_back_idle", IDLE_V);

    // Reset in BUSY with cnt=2
    next_cycle();
    divStartE = 1'b1;
    expect_ctl("rdiv_start", v(1,1,1,0,0,1,2'b00,2'b00,0,0));
    next_cycle();
    expect_ctl("rdiv_cnt3", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    next_cycle();
    expect_ctl("rdiv_cnt2", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    rst = 1'b1;
    expect_ctl("rst_mid_div_async", IDLE_V);
    next_cycle();
    expect_ctl("rst_held_no_done", IDLE_V);
    next_cycle();
    rst = 1'b0;
    expect_ctl("fresh_div_start", v(1,1,1,0,0,1,2'b00,2'b00,0,0));
    for (int i = 0; i < DIV_CYCLES - 1; i++) begin
      next_cycle();
      expect_ctl("fresh_div_stall", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    end
    next_cycle();
    divStartE = 1'b0;
    expect_ctl("fresh_div_done", v(0,0,0,0,0,0,2'b00,2'b00,1,1));

    // Perf counters: 1 load-use + 1 branch + 1 divide from a clean reset
    next_cycle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    push("perf_clear_stall", 32'd0); pop_cmp(stallCount);
    next_cycle();
    resultSelE = 2'b01; regAddr3E = 5'd7; regAddr1D = 5'd7;
    expect_ctl("perf_lw", v(1,1,0,0,1,0,2'b00,2'b00,0,0));
    next_cycle();
    clear_inputs();
    pcSrcE = 1'b1;
    expect_ctl("perf_branch", v(0,0,0,1,1,0,2'b00,2'b00,0,0));
    next_cycle();
    clear_inputs();
    divStartE = 1'b1;
    expect_ctl("perf_div_start", v(1,1,1,0,0,1,2'b00,2'b00,0,0));
    for (int i = 0; i < DIV_CYCLES - 1; i++) begin
      next_cycle();
      expect_ctl("perf_div_stall", v(1,1,1,0,0,1,2'b00,2'b00,1,0));
    end
    next_cycle();
    divStartE = 1'b0;
    expect_ctl("perf_div_done", v(0,0,0,0,0,0,2'b00,2'b00,1,1));
    next_cycle();
    expect_ctl("perf_idle", IDLE_V);
    push("perf_stall_count", EXP_STALL_CNT); pop_cmp(stallCount);
    push("perf_flush_count", EXP_FLUSH_CNT); pop_cmp(flushCount);

    if (sb_q.size() != 0) begin
      n_mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
